// File: rtl/wave_capture.sv
// -----------------------------------------------------------------------------
// wave_capture
//
// Upstream producer for the waveform display path. Watches the audio sample
// stream for a positive-going zero crossing (or, optionally, a forced trigger
// after AUTO_TRIG samples without one). It then captures 256 consecutive
// samples, converted to 8-bit offset binary, into one half of a 512-entry
// double-buffered sample RAM. The display reads half `read_index` while
// capture writes half `~read_index`. The halves are swapped only when the
// display reports idle, so every frame the display sees is complete and stable.
//
// Ports:
//   clk                input   system clock
//   reset              input   synchronous, active-low reset
//   new_sample_ready   input   one-cycle strobe, new_sample_in valid this cycle
//   new_sample_in      input   signed two's-complement audio sample
//   wave_display_idle  input   high while the display is outside active drawing
//   write_address      output  RAM write address {half, index[7:0]}
//   write_enable       output  RAM write strobe, one cycle per captured sample
//   write_sample       output  offset-binary 8-bit sample for the RAM
//   read_index         output  half the display reads (capture writes the other)
//   capture_state      output  current FSM state (ARMED=00, ACTIVE=01, WAIT=10)
//
// Handshake: new_sample_ready acts as a valid with an implicit, permanent
// ready. Every cycle with new_sample_ready=1 delivers exactly one sample, and
// that sample is consumed in that same cycle. Back-to-back strobes are legal
// and lose nothing. In ACTIVE, each accepted sample produces exactly one
// write_enable pulse on the following cycle.
// -----------------------------------------------------------------------------
module wave_capture #(
    parameter int SAMPLE_W  = 16,
    parameter int AUTO_TRIG = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [8:0]          write_address,
    output logic                write_enable,
    output logic [7:0]          write_sample,
    output logic                read_index,
    output logic [1:0]          capture_state
);

    // The counter only has to reach AUTO_TRIG-1. When auto-trigger is
    // disabled, the counter is a single free-running bit that is never
    // compared against anything.
    localparam int CNT_W = (AUTO_TRIG > 1) ? $clog2(AUTO_TRIG) : 1;
    localparam bit AUTO_EN = (AUTO_TRIG != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = AUTO_EN ? CNT_W'(AUTO_TRIG - 1) : '0;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_WAIT   = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         index;
    logic [7:0]         index_next;
    logic [CNT_W-1:0]   trig_count;
    logic [CNT_W-1:0]   trig_count_next;
    logic               read_index_next;
    logic [SAMPLE_W-1:0] prev_sample;

    logic               crossing;
    logic               auto_fire;
    logic               capture;
    logic [7:0]         capture_index;
    logic [7:0]         converted;

    // Only the sign of the previous sample drives the crossing detector. The
    // remaining bits are kept so that the register holds the full last sample.
    logic               prev_low_unused;
    assign prev_low_unused = ^prev_sample[SAMPLE_W-2:0];

    // Positive-going zero crossing: the previous sample was negative and this
    // one is non-negative. Because prev_sample resets to 0, nothing can fire
    // until a negative sample has been seen.
    assign crossing  = new_sample_ready
                       && prev_sample[SAMPLE_W-1]
                       && !new_sample_in[SAMPLE_W-1];
    assign auto_fire = AUTO_EN && (trig_count == CNT_LAST);

    // Offset binary: the top 8 bits with the sign inverted, so that 0x8000
    // maps to 0x00, 0x0000 maps to 0x80, and 0x7FFF maps to 0xFF.
    assign converted = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};

    assign capture_state = state;

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        index_next      = index;
        trig_count_next = trig_count;
        read_index_next = read_index;
        capture         = 1'b0;
        capture_index   = index;

        case (state)
            ST_ARMED: begin
                if (new_sample_ready) begin
                    if (crossing || auto_fire) begin
                        // The trigger sample itself is frame entry 0.
                        capture         = 1'b1;
                        capture_index   = 8'd0;
                        index_next      = 8'd1;
                        trig_count_next = '0;
                        state_next      = ST_ACTIVE;
                    end else begin
                        trig_count_next = trig_count + 1'b1;
                    end
                end
            end

            ST_ACTIVE: begin
                // Crossings are ignored here. Every strobe is one frame entry.
                if (new_sample_ready) begin
                    capture    = 1'b1;
                    index_next = index + 8'd1;
                    if (index == 8'hFF) begin
                        state_next = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // The swap happens only while the display is idle. A sample
                // arriving on this edge updates prev_sample, but ARMED does
                // not evaluate it for a trigger.
                if (wave_display_idle) begin
                    read_index_next = ~read_index;
                    trig_count_next = '0;
                    state_next      = ST_ARMED;
                end
            end

            default: begin
                // 2'b11 is unreachable. Recover to a clean ARMED state.
                index_next      = 8'd0;
                trig_count_next = '0;
                state_next      = ST_ARMED;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_ARMED;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Counters, buffer index and sample history
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            index       <= 8'd0;
            trig_count  <= '0;
            read_index  <= 1'b0;
            prev_sample <= '0;
        end else begin
            index      <= index_next;
            trig_count <= trig_count_next;
            read_index <= read_index_next;
            if (new_sample_ready) begin
                prev_sample <= new_sample_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered RAM write port. Address and data hold between pulses.
    // read_index cannot change while ACTIVE, so {~read_index, index} always
    // lands in the half the display is not reading.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_enable  <= 1'b0;
            write_address <= 9'd0;
            write_sample  <= 8'd0;
        end else begin
            write_enable <= capture;
            if (capture) begin
                write_address <= {~read_index, capture_index};
                write_sample  <= converted;
            end
        end
    end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Upstream producer for the waveform display path.
- Watches the audio sample stream and triggers on a positive-going zero crossing, then captures 256 consecutive samples as 8-bit unsigned values into one half of a 512-entry double-buffered sample RAM.
- Flips the buffer index only when the display reports idle, so the display always reads a complete, stable frame from half `read_index` while capture writes half `~read_index`.

Parameters:
- SAMPLE_W, 16, width of the signed two's-complement input sample.
- AUTO_TRIG, 1024, number of samples accepted in ARMED without a crossing before a forced trigger; 0 disables auto-trigger.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- new_sample_ready  input  1  one-cycle strobe; new_sample_in valid this cycle
- new_sample_in  input  SAMPLE_W  signed audio sample
- wave_display_idle  input  1  high while the display is outside its active drawing region
- write_address  output  9  RAM write address {half, index[7:0]}
- write_enable  output  1  RAM write strobe, one cycle per captured sample
- write_sample  output  8  unsigned sample to RAM
- read_index  output  1  half the display reads; capture writes ~read_index
- capture_state  output  2  current state encoding (debug/verification)

Behaviour:
- One clock. Reset is synchronous and active-low. All state changes on the rising clk edge.
- Reset (reset==0 at an edge) values:
  - state=ARMED, read_index=0, write_enable=0, write_address=0, write_sample=0.
  - Sample index=0, auto-trigger count=0, prev_sample=0.
  - Reset overrides every other input, including mid-capture.
- State encoding: ARMED=2'b00, ACTIVE=2'b01, WAIT=2'b10. 2'b11 is unreachable and returns to ARMED on the next edge.
- Conversion: write_sample = {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]}. This is the top 8 bits with the sign flipped (offset binary).
  - Examples: 0x8000 -> 0x00, 0x0000 -> 0x80, 0x7FFF -> 0xFF.
- prev_sample:
  - Loads new_sample_in on every cycle with new_sample_ready=1, in every state.
  - Holds when new_sample_ready=0.
- Crossing: crossing = prev_sample[MSB]==1 AND new_sample_in[MSB]==0, evaluated only when new_sample_ready=1.
  - Because reset value is 0, no trigger occurs until a negative sample has been seen.
- ARMED:
  - On new_sample_ready with crossing, or with auto-trigger count == AUTO_TRIG-1 (when AUTO_TRIG != 0):
    - Capture this sample as index 0 and go to ACTIVE with index=1.
    - Clear the auto-trigger count.
  - On new_sample_ready with neither condition, increment the auto-trigger count.
  - Cycles without new_sample_ready change nothing.
- ACTIVE:
  - On each new_sample_ready, capture the sample at the current index and increment index.
  - The capture that writes index 255 moves to WAIT; index wraps to 0.
  - Crossings are ignored in ACTIVE.
- Capture write timing (1-cycle latency):
  - Registered outputs on the edge after the accepting cycle: write_enable=1, write_address={~read_index, index}, write_sample=converted sample.
  - write_enable is 0 on all other cycles. write_address and write_sample hold their last value when write_enable=0.
  - Exactly 256 write pulses per frame, addresses strictly ascending within one half.
- WAIT:
  - No writes. Samples still update prev_sample but are never captured.
  - When wave_display_idle==1 at an edge: toggle read_index and go to ARMED, clearing the auto-trigger count.
  - A sample arriving on that same edge is not evaluated for trigger; ARMED evaluation starts the following cycle.
- Back-to-back new_sample_ready on consecutive cycles must be accepted without loss, one write per cycle.
- read_index changes only on the WAIT->ARMED transition. It never changes while write_enable is asserted or in the same cycle as a write.
- Reset mid-ACTIVE: the partial frame is abandoned, read_index returns to 0, and no further writes occur until a new trigger.

Test Plan:
- Reset: hold reset=0 for 3 cycles with samples streaming -> all outputs 0, capture_state=00; release -> first write only after a negative-then-non-negative pair.
- Trigger and capture: feed 0xFF00 then a ramp 0x0000, 0x0100, … one sample every 4 cycles -> 256 write pulses, addresses 0x100..0x1FF, write_sample 0x80, 0x81, …, each pulse exactly 1 cycle after its strobe; capture_state=10 after the 256th.
- Buffer flip: in WAIT hold wave_display_idle=0 for 50 cycles -> read_index stays 0, no writes; raise idle -> read_index=1 next edge, state ARMED; next frame writes 0x000..0x0FF.
- Back-to-back: new_sample_ready held high for 256 cycles after a trigger -> 256 consecutive write_enable cycles with no gaps or duplicates.
- Auto-trigger with AUTO_TRIG=16: constant 0x1234 stream -> the 16th accepted sample triggers, writing 0x92 at index 0; AUTO_TRIG=0 with the same stream -> no writes for 1000 samples.
- Reset mid-capture: assert reset after index 100 -> write_enable=0 the next cycle, read_index=0, state ARMED; the next crossing restarts at index 0.
